// File: rtl/rk4_cmd_pkg.sv
// Shared types and constants for the RK4 command front end.
// Holds the parser state encoding, the default sync marker, payload length
// and the opcode values the projectile core understands.
package rk4_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         PAYLOAD_LEN   = 4;

  // Opcodes consumed by the core; the receiver passes them through unchecked.
  localparam logic [7:0] OP_RUN  = 8'h01;
  localparam logic [7:0] OP_STOP = 8'h02;

endpackage

// File: rtl/rk4_uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser.
// Ports: clk, rst_n (sync, active-low), uart_rx (async line, idle high);
//        rx_byte/rx_valid (1-cycle strobe after a good stop bit), frame_err (1-cycle pulse).
module rk4_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic          meta_q, sync_q, prev_q;
  rx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          vld_q, vld_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= uart_rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Edge rather than level, so a line held low after a bad stop bit
        // does not retrigger endlessly.
        if (prev_q && !sync_q) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};  // LSB arrives first
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d  = '0;
          vld_d  = sync_q;
          ferr_d = !sync_q;
          st_d   = RX_IDLE;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  assign rx_byte   = shift_q;
  assign rx_valid  = vld_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/rk4_cmd_rx.sv
// RK4 command receiver: UART bytes -> framed, XOR-checked launch command.
// Ports: clk, rst_n (sync, active-low), uart_rx; cmd_valid/cmd_ready handshake with
//        cmd_op/cmd_v0/cmd_theta; busy; 1-cycle error pulses frame/chk/timeout/overrun.
module rk4_cmd_rx
  import rk4_cmd_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         TIMEOUT_CLKS = 40000,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [7:0]  cmd_op,
  output logic [15:0] cmd_v0,
  output logic [15:0] cmd_theta,
  output logic        busy,
  output logic        frame_err,
  output logic        chk_err,
  output logic        timeout_err,
  output logic        overrun_err
);

  localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;

  rk4_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  state_e        state_q, state_d;
  logic [7:0]    op_stage_q, op_stage_d;
  logic [31:0]   pay_q, pay_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    cmd_op_q, cmd_op_d;
  logic [15:0]   cmd_v0_q, cmd_v0_d;
  logic [15:0]   cmd_th_q, cmd_th_d;
  logic          chk_err_q, chk_err_d;
  logic          tmo_err_q, tmo_err_d;
  logic          ovr_err_q, ovr_err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_stage_q <= '0;
      pay_q      <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      tmo_q      <= '0;
      cmd_op_q   <= '0;
      cmd_v0_q   <= '0;
      cmd_th_q   <= '0;
      chk_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_stage_q <= op_stage_d;
      pay_q      <= pay_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      tmo_q      <= tmo_d;
      cmd_op_q   <= cmd_op_d;
      cmd_v0_q   <= cmd_v0_d;
      cmd_th_q   <= cmd_th_d;
      chk_err_q  <= chk_err_d;
      tmo_err_q  <= tmo_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_stage_d = op_stage_q;
    pay_d      = pay_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    tmo_d      = '0;
    cmd_op_d   = cmd_op_q;
    cmd_v0_d   = cmd_v0_q;
    cmd_th_d   = cmd_th_q;
    chk_err_d  = 1'b0;
    tmo_err_d  = 1'b0;
    ovr_err_d  = 1'b0;

    // Inter-byte watchdog for the mid-packet states. A byte in the expiry
    // cycle wins because the expiry branch is only taken without rx_valid.
    if (state_q == ST_OP || state_q == ST_PAYLOAD || state_q == ST_CHK) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_err_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_byte == SYNC_BYTE) state_d = ST_OP;
      end
      ST_OP: begin
        if (rx_valid) begin
          op_stage_d = rx_byte;
          xor_d      = rx_byte;
          idx_d      = '0;
          state_d    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          pay_d = {pay_q[23:0], rx_byte};  // MSB-first shift
          xor_d = xor_q ^ rx_byte;
          idx_d = idx_q + 1'b1;
          if (idx_q == 2'(PAYLOAD_LEN - 1)) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_byte == xor_q) begin
            cmd_op_d = op_stage_q;
            cmd_v0_d = pay_q[31:16];
            cmd_th_d = pay_q[15:0];
            state_d  = ST_HOLD;
          end else begin
            chk_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // Staging registers are not reused while holding, so any new byte
        // is lost, including one landing in the handshake cycle.
        if (rx_valid) ovr_err_d = 1'b1;
        if (cmd_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_valid   = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign cmd_op      = cmd_op_q;
  assign cmd_v0      = cmd_v0_q;
  assign cmd_theta   = cmd_th_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = tmo_err_q;
  assign overrun_err = ovr_err_q;

endmodule

// File: tb/tb_rk4_cmd_rx.sv
// Directed bench for rk4_cmd_rx with CLKS_PER_BIT=4, TIMEOUT_CLKS=200.
// Drives UART frames on the falling clock edge and samples outputs there too.
// Pulse activity is tallied by a monitor; steps compare tally deltas and outputs.
module tb_rk4_cmd_rx;

  localparam int CPB = 4;
  localparam int TMO = 200;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        uart_rx   = 1'b1;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_v0;
  logic [15:0] cmd_theta;
  logic        busy;
  logic        frame_err;
  logic        chk_err;
  logic        timeout_err;
  logic        overrun_err;

  always #5 clk = ~clk;

  rk4_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_v0      (cmd_v0),
    .cmd_theta   (cmd_theta),
    .busy        (busy),
    .frame_err   (frame_err),
    .chk_err     (chk_err),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Running tallies of output activity, written only by the monitor.
  int          n_valid = 0, n_chk = 0, n_tmo = 0, n_ovr = 0, n_ferr = 0, n_rxv = 0;
  logic [7:0]  last_op;
  logic [15:0] last_v0, last_th;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) begin
        n_valid++;
        last_op = cmd_op;
        last_v0 = cmd_v0;
        last_th = cmd_theta;
      end
      if (chk_err)        n_chk++;
      if (timeout_err)    n_tmo++;
      if (overrun_err)    n_ovr++;
      if (frame_err)      n_ferr++;
      if (dut.rx_valid)   n_rxv++;
    end
  end

  int b_valid, b_chk, b_tmo, b_ovr, b_ferr, b_rxv;

  task automatic snap();
    b_valid = n_valid; b_chk = n_chk; b_tmo = n_tmo;
    b_ovr = n_ovr; b_ferr = n_ferr; b_rxv = n_rxv;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [55:0] pkt);
    for (int k = 6; k >= 0; k--) send_byte(pkt[k*8 +: 8], 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ok;
    int t;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_op", cmd_op, 0);
    check("rst_v0", cmd_v0, 0);
    check("rst_theta", cmd_theta, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {frame_err, chk_err, timeout_err, overrun_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good packet, core always ready: single-cycle valid
    cmd_ready = 1'b1;
    snap();
    send_pkt(56'hA5_01_12_34_00_2D_0A);
    repeat (10) @(negedge clk);
    check("s1_valid_cycles", n_valid - b_valid, 1);
    check("s1_op", last_op, 8'h01);
    check("s1_v0", last_v0, 16'h1234);
    check("s1_theta", last_th, 16'h002D);
    check("s1_err_pulses", (n_chk - b_chk) + (n_tmo - b_tmo) + (n_ovr - b_ovr) + (n_ferr - b_ferr), 0);
    check("s1_busy", busy, 0);

    // Same packet held for 50 cycles of backpressure
    cmd_ready = 1'b0;
    snap();
    send_pkt(56'hA5_01_12_34_00_2D_0A);
    repeat (2) @(negedge clk);
    check("s2_valid_up", cmd_valid, 1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1 && {cmd_op, cmd_v0, cmd_theta} === {8'h01, 16'h1234, 16'h002D}) ok++;
    end
    check("s2_hold_stable", ok, 50);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("s2_valid_clear", cmd_valid, 0);
    check("s2_busy_clear", busy, 0);

    // Bad checksum, then a different good packet
    snap();
    send_pkt(56'hA5_01_12_34_00_2D_0B);
    repeat (10) @(negedge clk);
    check("s3_chk_pulses", n_chk - b_chk, 1);
    check("s3_no_valid", n_valid - b_valid, 0);
    check("s3_busy", busy, 0);
    check("s3_v0_unchanged", cmd_v0, 16'h1234);
    snap();
    send_pkt(56'hA5_02_00_80_01_00_83);
    repeat (10) @(negedge clk);
    check("s3b_valid_cycles", n_valid - b_valid, 1);
    check("s3b_op", last_op, 8'h02);
    check("s3b_v0", last_v0, 16'h0080);
    check("s3b_theta", last_th, 16'h0100);
    check("s3b_chk_pulses", n_chk - b_chk, 0);

    // Truncated packet times out, then a full packet decodes
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    check("s4_busy_mid", busy, 1);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (t < 0 && n_tmo != b_tmo) t = i;
    end
    check("s4_tmo_pulses", n_tmo - b_tmo, 1);
    check("s4_tmo_window", (t >= 180 && t <= 200), 1);
    check("s4_busy_after", busy, 0);
    snap();
    send_pkt(56'hA5_01_12_34_00_2D_0A);
    repeat (10) @(negedge clk);
    check("s4b_valid_cycles", n_valid - b_valid, 1);
    check("s4b_op", last_op, 8'h01);

    // Framing error, then a one-cycle glitch
    snap();
    send_byte(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    check("s5_ferr_pulses", n_ferr - b_ferr, 1);
    check("s5_no_rxv", n_rxv - b_rxv, 0);
    check("s5_busy", busy, 0);
    snap();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("s5_glitch_rxv", n_rxv - b_rxv, 0);
    check("s5_glitch_ferr", n_ferr - b_ferr, 0);

    // Overrun while holding
    cmd_ready = 1'b0;
    snap();
    send_pkt(56'hA5_02_00_80_01_00_83);
    repeat (2) @(negedge clk);
    check("s6_valid_up", cmd_valid, 1);
    send_byte(8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    check("s6_ovr_pulses", n_ovr - b_ovr, 1);
    check("s6_hold_valid", cmd_valid, 1);
    check("s6_hold_out", {cmd_op, cmd_v0, cmd_theta}, {8'h02, 16'h0080, 16'h0100});
    cmd_ready = 1'b1;
    @(negedge clk);
    check("s6_valid_clear", cmd_valid, 0);

    // Reset mid-packet
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check("s7_busy_mid", busy, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("s7_valid", cmd_valid, 0);
    check("s7_op", cmd_op, 0);
    check("s7_v0", cmd_v0, 0);
    check("s7_theta", cmd_theta, 0);
    check("s7_busy", busy, 0);
    check("s7_errs", {frame_err, chk_err, timeout_err, overrun_err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    snap();
    send_pkt(56'hA5_01_12_34_00_2D_0A);
    repeat (10) @(negedge clk);
    check("s7b_valid_cycles", n_valid - b_valid, 1);
    check("s7b_v0", last_v0, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rk4_cmd_rx.md
Name: rk4_cmd_rx

Overview:
- Upstream command front end for the RK4 projectile core.
- Deserialises the host UART line (8N1) into bytes and frames them into fixed-length command packets.
- Verifies each packet's XOR checksum and presents the decoded launch parameters to the core over a valid/ready handshake.
- Runs on the divided core clock.

Parameters:
- CLKS_PER_BIT, 868: core clock cycles per UART bit. Must be >= 4.
- TIMEOUT_CLKS, 40000: maximum idle cycles allowed between bytes inside a packet.
- SYNC_BYTE, 8'hA5: packet start marker.

Ports:
- clk  in  1  core clock (all logic on rising edge)
- rst_n  in  1  reset, synchronous, active-low
- uart_rx  in  1  asynchronous serial input; idle high
- cmd_ready  in  1  core accepts the command this cycle
- cmd_valid  out  1  decoded command available
- cmd_op  out  8  opcode byte
- cmd_v0  out  16  initial velocity, Q8.8
- cmd_theta  out  16  launch angle, Q8.8
- busy  out  1  parser is past IDLE (mid-packet or holding)
- frame_err  out  1  1-cycle pulse: stop bit sampled low
- chk_err  out  1  1-cycle pulse: checksum mismatch
- timeout_err  out  1  1-cycle pulse: inter-byte timeout
- overrun_err  out  1  1-cycle pulse: byte dropped while holding

Behaviour:
- Reset:
  - Synchronous, applied on any edge with rst_n=0; a partial packet is discarded.
  - uart_rx synchroniser flops go to 1.
  - RX returns to idle; parser state goes to IDLE.
  - All outputs are 0, including payload registers.
- Input synchroniser: 2-flop synchroniser on uart_rx; all logic uses the synchronised signal.
- RX (8N1, LSB first):
  - A falling edge starts the start-bit check.
  - Re-sample at CLKS_PER_BIT/2: if high, treat as a glitch and return to idle.
  - Then sample every CLKS_PER_BIT for 8 data bits and the stop bit.
  - Stop bit=1: the internal rx_valid pulses for 1 cycle on the cycle after the stop sample.
  - Stop bit=0: frame_err pulses instead and the byte is dropped.
  - RX then returns to idle and can detect a new falling edge immediately.
- Packet format: SYNC_BYTE, OP, V0_HI, V0_LO, TH_HI, TH_LO, CHK.
  - CHK = OP ^ V0_HI ^ V0_LO ^ TH_HI ^ TH_LO.
- Parser FSM states: IDLE, OP, PAYLOAD, CHK, HOLD.
  - IDLE: advance to OP only on byte == SYNC_BYTE; ignore all other bytes silently.
  - OP: store opcode and seed the running XOR. Opcodes are not validated.
  - PAYLOAD: store 4 bytes, MSB first, using a 2-bit counter; XOR-accumulate; go to CHK after the 4th byte.
  - CHK, byte == running XOR: load cmd_op/cmd_v0/cmd_theta and go to HOLD. cmd_valid=1 on the cycle after the checksum rx_valid.
  - CHK, mismatch: chk_err pulse, go to IDLE, outputs unchanged.
  - HOLD: cmd_valid stays high and outputs stay stable until cmd_valid & cmd_ready, then IDLE next cycle with cmd_valid=0. If cmd_ready is already high, cmd_valid is a 1-cycle pulse.
  - Byte arriving in HOLD: dropped with an overrun_err pulse, even if it is SYNC_BYTE.
- Timeout:
  - Counter resets on every rx_valid and runs in OP, PAYLOAD and CHK.
  - On reaching TIMEOUT_CLKS: timeout_err pulse, go to IDLE.
  - Not active in IDLE or HOLD.
- busy = (state != IDLE).
- frame_err has no effect on parser state; the timeout recovers the parser.
- Simultaneous events:
  - rx_valid and timeout expiry in the same cycle: the byte wins and the counter clears.
  - Handshake completion and rx_valid in the same HOLD cycle: the byte is dropped with an overrun_err pulse.

Decomposition:
- Package rk4_cmd_pkg:
  - parser state enum
  - SYNC_BYTE default
  - PAYLOAD_LEN=4
  - opcode constants OP_RUN=8'h01, OP_STOP=8'h02, for core use
- Sub-module rk4_uart_rx (synchroniser + bit-timing FSM), with outputs rx_byte[7:0], rx_valid, frame_err.
- Parser FSM lives in rk4_cmd_rx.

Test Plan:
- CLKS_PER_BIT=4, TIMEOUT_CLKS=200 for all scenarios.
- Send A5 01 12 34 00 2D 0A with cmd_ready=1: cmd_valid pulses 1 cycle with op=01, v0=1234, theta=002D, no error pulses.
- Same packet with cmd_ready=0 for 50 cycles, then 1: cmd_valid and outputs stay stable for 50 cycles; cmd_valid clears the cycle after the handshake.
- Same packet with last byte 0B: chk_err pulses once, cmd_valid stays 0, busy=0 afterwards; a following correct packet decodes normally.
- Send A5 01 12, idle 300 cycles, then a full valid packet: timeout_err pulses once ~200 cycles after byte 12; the second packet decodes.
- Byte 55 with stop bit forced 0: frame_err pulses, no rx_valid; a 1-cycle low glitch on uart_rx yields no byte and no error.
- Hold a decoded packet with cmd_ready=0 and send A5: overrun_err pulses and held outputs are unchanged; separately, assert rst_n=0 after byte 34 and confirm all outputs are 0 and busy=0.
